// File: rtl/pattern_tx_if.sv
// Payload handshake and serial link bundle for pattern_tx.
//
// Signals:
//   in_valid    producer -> tx   payload word offered
//   in_data     producer -> tx   payload word (DATA_W bits)
//   in_ready    tx -> producer   transmitter can take a word this cycle
//   out         tx -> link       serial bit
//   out_valid   tx -> link       out carries a sync or payload bit
//   frame_start tx -> link       pulse with the first sync bit
//   frame_end   tx -> link       pulse with the last payload bit
//   busy        tx -> producer   transmitter not idle
//
// Modports:
//   master  the producer / link observer side
//   slave   the transmitter side
interface pattern_tx_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out;
  logic              out_valid;
  logic              frame_start;
  logic              frame_end;
  logic              busy;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out,
    input  out_valid,
    input  frame_start,
    input  frame_end,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out,
    output out_valid,
    output frame_start,
    output frame_end,
    output busy
  );

endinterface

// File: rtl/pattern_tx.sv
// Framed serial transmitter.
//
// Takes one payload word over a valid/ready handshake and sends, one bit per clock:
// the sync pattern (MSB first), the payload (MSB first), then GAP_LEN forced-zero
// idle bit times. The handshake cycle itself is always an idle cycle, so back-to-back
// frames start every 1 + SYNC_LEN + DATA_W + GAP_LEN cycles.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  pattern_tx_if.slave: in_valid/in_data/in_ready handshake, registered serial
//        outputs out/out_valid/frame_start/frame_end, and busy (decoded from state,
//        as is in_ready).
//
// The payload is not bit-stuffed; a payload containing the sync pattern can alias at
// a downstream detector.
module pattern_tx #(
  parameter int unsigned         SYNC_LEN = 5,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = 5'b10010,
  parameter int unsigned         DATA_W   = 8,
  parameter int unsigned         GAP_LEN  = 2
) (
  input  logic         clk,
  input  logic         rst,
  pattern_tx_if.slave  bus
);

  localparam int unsigned FRAME_W  = SYNC_LEN + DATA_W;
  localparam int unsigned MAX_SD   = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int unsigned MAX_LEN  = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
  localparam int unsigned CNT_W    = $clog2(MAX_LEN + 1);

  // Counter reload values: the index of the last bit time of each state.
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Elaboration-time range checks on the parameters.
  if (SYNC_LEN < 1 || SYNC_LEN > 16) begin : g_bad_sync_len
    $error("pattern_tx: SYNC_LEN must be in 1..16");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
    $error("pattern_tx: DATA_W must be in 1..32");
  end
  if (GAP_LEN > 15) begin : g_bad_gap_len
    $error("pattern_tx: GAP_LEN must be in 0..15");
  end

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StSync = 2'b01,
    StData = 2'b10,
    StGap  = 2'b11
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [FRAME_W-1:0]   shift_q;
  logic                 out_q;
  logic                 out_valid_q;
  logic                 frame_start_q;
  logic                 frame_end_q;

  // Sync pattern and payload are loaded together so a single shift register feeds
  // both the SYNC and DATA phases; the counter only marks the phase boundaries.
  logic [FRAME_W-1:0]   frame_load;
  assign frame_load = {SYNC_PAT, bus.in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      shift_q       <= '0;
      out_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      // Both markers are single-cycle pulses unless set below.
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          if (bus.in_valid) begin
            // The first sync bit goes out on the capture edge itself.
            state_q       <= StSync;
            cnt_q         <= SYNC_LAST;
            shift_q       <= frame_load << 1;
            out_q         <= frame_load[FRAME_W-1];
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
          end
        end

        StSync: begin
          // Whether or not this is the last sync bit, the next bit is the MSB of
          // what remains in the shift register.
          out_q       <= shift_q[FRAME_W-1];
          out_valid_q <= 1'b1;
          shift_q     <= shift_q << 1;
          if (cnt_q == '0) begin
            state_q     <= StData;
            cnt_q       <= DATA_LAST;
            frame_end_q <= (DATA_W == 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StData: begin
          if (cnt_q == '0) begin
            // Last payload bit is on the line now; drop to gap or idle.
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            if (GAP_LEN > 0) begin
              state_q <= StGap;
              cnt_q   <= GAP_LAST;
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end else begin
            out_q       <= shift_q[FRAME_W-1];
            out_valid_q <= 1'b1;
            shift_q     <= shift_q << 1;
            cnt_q       <= cnt_q - 1'b1;
            frame_end_q <= (cnt_q == CNT_ONE);
          end
        end

        StGap: begin
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q       <= StIdle;
          cnt_q         <= '0;
          shift_q       <= '0;
          out_q         <= 1'b0;
          out_valid_q   <= 1'b0;
          frame_start_q <= 1'b0;
          frame_end_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: a cycle table for reset and a single frame, hand-written
// multi-cycle sequences, a second instance with short parameters, and a random run
// against a frame-position model.
module tb_pattern_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_tx_if #(.DATA_W(8)) bus ();
  pattern_tx_if #(.DATA_W(4)) bus6 ();

  pattern_tx u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pattern_tx #(
    .SYNC_LEN (3),
    .SYNC_PAT (3'b101),
    .DATA_W   (4),
    .GAP_LEN  (0)
  ) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {out, out_valid, frame_start, frame_end, in_ready, busy}
  function automatic logic [5:0] obs();
    return {bus.out, bus.out_valid, bus.frame_start, bus.frame_end, bus.in_ready, bus.busy};
  endfunction

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic v, input logic [7:0] d,
                              input logic o, input logic ov, input logic fs,
                              input logic fe, input logic rdy, input logic bsy);
    vec_t t;
    t.rst   = r;
    t.valid = v;
    t.data  = d;
    t.exp   = {o, ov, fs, fe, rdy, bsy};
    vecs.push_back(t);
  endfunction

  // Frame-position model for the default instance: pos 0 is idle, pos k >= 1 is the
  // k-th cycle after the handshake edge. Frame bits occupy pos 1..13, gap 14..15.
  int          m_pos = 0;
  logic [12:0] m_frame = '0;

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    if (r) begin
      m_pos = 0;
    end else if (m_pos == 0) begin
      if (v) begin
        m_frame = {5'b10010, d};
        m_pos   = 1;
      end
    end else begin
      m_pos++;
      if (m_pos > 15) m_pos = 0;
    end
  endtask

  function automatic logic [5:0] model_exp();
    logic ov;
    logic o;
    ov = (m_pos >= 1 && m_pos <= 13);
    o  = ov ? m_frame[13 - m_pos] : 1'b0;
    return {o, ov, m_pos == 1, m_pos == 13, m_pos == 0, m_pos != 0};
  endfunction

  task automatic send_frame(input logic [7:0] d, output logic [12:0] bits,
                            output int n_bits, output int n_fe);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bits   = '0;
    n_bits = 0;
    n_fe   = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        bits = {bits[11:0], bus.out};
        n_bits++;
      end
      if (bus.frame_end) n_fe++;
    end
  endtask

  initial begin
    logic [12:0] exp_bits;
    logic [12:0] bits;
    logic [12:0] fr [2];
    logic [6:0]  f6 [2];
    logic [2:0]  win;
    int          fs_cyc[$];
    int          fs6[$];
    int          n_bits;
    int          n_fe;
    int          cnt;
    int          det;
    int          diff;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus6.in_valid = 1'b0;
    bus6.in_data  = '0;

    // Reset with in_valid high, then a single A5 frame, gap, idle.
    exp_bits = 13'b1001010100101;
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 8'hA5, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 13; i++) begin
      add(1'b0, i == 0, 8'hA5, exp_bits[12-i], 1, i == 0, i == 12, 0, 1);
    end
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 8'hA5, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) add(1'b0, 1'b0, 8'hA5, 0, 0, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      rst          = vecs[i].rst;
      bus.in_valid = vecs[i].valid;
      bus.in_data  = vecs[i].data;
      tick();
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Back-to-back: FF then 00 with in_valid held.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    fr[0] = '0;
    fr[1] = '0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.frame_start) begin
        fs_cyc.push_back(c);
        if (fs_cyc.size() == 1) bus.in_data = 8'h00;
        else bus.in_valid = 1'b0;
      end
      if (bus.out_valid && fs_cyc.size() >= 1 && fs_cyc.size() <= 2) begin
        fr[fs_cyc.size()-1] = {fr[fs_cyc.size()-1][11:0], bus.out};
      end
      if (fs_cyc.size() == 2 && !bus.busy) break;
    end
    bus.in_valid = 1'b0;
    check("t3_frames", fs_cyc.size(), 2);
    diff = (fs_cyc.size() >= 2) ? fs_cyc[1] - fs_cyc[0] : -1;
    check("t3_period", diff, 16);
    check("t3_frame0", fr[0], {5'b10010, 8'hFF});
    check("t3_frame1", fr[1], {5'b10010, 8'h00});
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.frame_start) cnt++;
    end
    check("t3_no_extra", cnt, 0);

    // in_data / in_valid changes during DATA are ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    check("t4_start", bus.frame_start, 1'b1);
    bus.in_valid = 1'b0;
    bits = {12'b0, bus.out};
    cnt  = 0;
    for (int c = 2; c <= 15; c++) begin
      if (c == 8) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
      end
      if (c == 9) bus.in_valid = 1'b0;
      tick();
      if (bus.out_valid) bits = {bits[11:0], bus.out};
      if (bus.in_ready) cnt++;
    end
    check("t4_ready_low", cnt, 0);
    check("t4_payload", bits, {5'b10010, 8'hA5});
    tick();
    check("t4_ready_idle", bus.in_ready, 1'b1);
    check("t4_no_new_frame", bus.busy, 1'b0);

    // Reset while payload bit 4 is on the line.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 2; c <= 9; c++) tick();
    check("t5_pre_rst_busy", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_after_rst", obs(), 6'b000010);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.frame_end || bus.frame_start || bus.busy) cnt++;
    end
    check("t5_abandoned", cnt, 0);
    send_frame(8'h5A, bits, n_bits, n_fe);
    check("t5_next_bits", bits, {5'b10010, 8'h5A});
    check("t5_next_len", n_bits, 13);
    check("t5_next_fe", n_fe, 1);

    // Short-parameter instance: no gap, 3-bit sync 101, 4-bit payload 6.
    bus6.in_valid = 1'b1;
    bus6.in_data  = 4'h6;
    f6[0] = '0;
    f6[1] = '0;
    win   = '0;
    det   = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus6.frame_start) fs6.push_back(c);
      if (bus6.out_valid) begin
        win = {win[1:0], bus6.out};
        if (fs6.size() >= 1 && fs6.size() <= 2) begin
          f6[fs6.size()-1] = {f6[fs6.size()-1][5:0], bus6.out};
        end
      end
      // Downstream detector view: the sync has fully arrived two cycles after start.
      if (fs6.size() > 0 && c == fs6[fs6.size()-1] + 2 && win == 3'b101) det++;
      if (fs6.size() == 3) bus6.in_valid = 1'b0;
    end
    check("t6_frames", fs6.size(), 3);
    diff = (fs6.size() >= 2) ? fs6[1] - fs6[0] : -1;
    check("t6_period01", diff, 8);
    diff = (fs6.size() >= 3) ? fs6[2] - fs6[1] : -1;
    check("t6_period12", diff, 8);
    check("t6_frame0", f6[0], 7'b1010110);
    check("t6_frame1", f6[1], 7'b1010110);
    check("t6_detect", det, 3);
    check("t6_idle", bus6.busy, 1'b0);

    // Random traffic against the model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pos = 0;
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic       v;
      logic [7:0] d;
      r = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 1) == 1);
      d = 8'($urandom);
      rst          = r;
      bus.in_valid = v;
      bus.in_data  = d;
      tick();
      model_step(r, v, d);
      check($sformatf("rand%0d", n), obs(), model_exp());
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
